mips_dmem_ctrl: RTL



---
 rtl/mips_mem_pkg.sv | 64 ++++++
 rtl/dmem_lane_align.sv | 32 +++
 rtl/mips_dmem_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and lane helpers for the MIPS data memory controller.
// Size encodings, FSM states and big-endian lane select / extend functions.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  // Byte enables, bit 3 = lane [31:24] = byte offset 0 (big-endian).
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b1000 >> off;
      SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-shift that brings the addressed lanes down to bit 0.
  function automatic logic [4:0] lane_shift(input size_e sz, input logic [1:0] off);
    logic [4:0] s;
    case (sz)
      SZ_BYTE: s = {~off, 3'b000};
      SZ_HALF: s = {~off[1], 1'b0, 3'b000};
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input size_e sz, input logic sgn);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {{24{sgn & v[7]}}, v[7:0]};
      SZ_HALF: r = {{16{sgn & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    logic e;
    case (sz)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges store data into the old word and
// extracts/extends load data; flags misaligned or illegal-size accesses.
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] load,
  output logic        misalign
);

  logic [3:0]  mask_s;
  logic [4:0]  shift_s;
  logic [31:0] bmask_s;
  logic [31:0] ins_s;

  // Lane steering for both the store merge and the load extract.
  always_comb begin
    mask_s   = lane_mask(size, off);
    shift_s  = lane_shift(size, off);
    bmask_s  = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
    ins_s    = wdata << shift_s;
    merged   = (old_word & ~bmask_s) | (ins_s & bmask_s);
    load     = extend(old_word >> shift_s, size, sgn);
    misalign = misaligned(size, off);
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// MIPS data memory controller: valid/ready front end, wait states, sized
// big-endian load/store. Optional power-up array clear under DMEM_CLEAR_EN.
module mips_dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 0,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DEPTH_LOG2+1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
`ifdef DMEM_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
  localparam logic   RST_READY = 1'b0;
`else
  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_READY = 1'b1;
`endif

  state_e                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic                    we_r, sgn_r;
  size_e                   size_r;
  logic [DEPTH_LOG2+1:0]   addr_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [DATA_W-1:0]       ld_r;
  logic                    err_r;
  logic                    req_ready_r, rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0]       rsp_rdata_r;
  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic                    mem_we_s;
  logic [DEPTH_LOG2-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]       mem_wdata_s;
  logic [DATA_W-1:0]       mem_rd_s, merged_s, load_s;
  logic                    misalign_s;
  logic                    accept_s;
`ifdef DMEM_CLEAR_EN
  logic [DEPTH_LOG2-1:0]   clr_r;
`endif

  assign accept_s  = req_valid & req_ready_r;
  assign mem_rd_s  = mem_r[addr_r[DEPTH_LOG2+1:2]];
  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  dmem_lane_align u_align (
    .size     (size_r),
    .off      (addr_r[1:0]),
    .sgn      (sgn_r),
    .wdata    (wdata_r),
    .old_word (mem_rd_s),
    .merged   (merged_s),
    .load     (load_s),
    .misalign (misalign_s)
  );

  // Next-state, wait counter and array write-port selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_r[DEPTH_LOG2+1:2];
    mem_wdata_s = merged_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WS_LAST) begin
          state_s = ST_ACCESS;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_ACCESS: begin
        state_s  = ST_RESP;
        mem_we_s = we_r & ~misalign_s;
      end
      ST_RESP: state_s = ST_IDLE;
`ifdef DMEM_CLEAR_EN
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        if (clr_r == {DEPTH_LOG2{1'b1}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, request capture and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RST_STATE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      sgn_r       <= 1'b0;
      size_r      <= SZ_WORD;
      addr_r      <= '0;
      wdata_r     <= '0;
      ld_r        <= '0;
      err_r       <= 1'b0;
      req_ready_r <= RST_READY;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_ready_r <= (state_s == ST_IDLE);
      if (state_r == ST_IDLE && accept_s) begin
        we_r    <= req_we;
        sgn_r   <= req_signed;
        size_r  <= size_e'(req_size);
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      // Stores and faulted requests always answer with zero data.
      if (state_r == ST_ACCESS) begin
        ld_r  <= (we_r | misalign_s) ? '0 : load_s;
        err_r <= misalign_s;
      end
      rsp_valid_r <= (state_r == ST_RESP);
      rsp_rdata_r <= (state_r == ST_RESP) ? ld_r : '0;
      rsp_err_r   <= (state_r == ST_RESP) & err_r;
    end
  end

`ifdef DMEM_CLEAR_EN
  // Clear sweep pointer; held at zero outside CLEAR so a reset restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      clr_r <= clr_r + 1'b1;
    end else begin
      clr_r <= '0;
    end
  end
`endif

  // Array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

endmodule
